// File: rtl/stc_pkg.sv
// Shared types and default sizing for the stage controller and its scoreboard.
package stc_pkg;

   localparam int unsigned REG_NUM    = 32;
   localparam int unsigned RIDX_WIDTH = 5;
   localparam int unsigned INFL_WIDTH = 3;

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StRedir = 2'd1,
      StDrain = 2'd2
   } stc_state_e;

endpackage

// File: rtl/stc_scoreboard.sv
// Per-register write-pending bits with set-over-clear priority and a two-source RAW lookup.
module stc_scoreboard #(
   parameter int unsigned REG_NUM    = stc_pkg::REG_NUM,
   parameter int unsigned RIDX_WIDTH = stc_pkg::RIDX_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_en,
   input  logic [RIDX_WIDTH-1:0] set_idx,
   input  logic                  clr_en,
   input  logic [RIDX_WIDTH-1:0] clr_idx,
   input  logic [RIDX_WIDTH-1:0] rs1_idx,
   input  logic                  rs1_rd,
   input  logic [RIDX_WIDTH-1:0] rs2_idx,
   input  logic                  rs2_rd,
   output logic                  hazard
);

   logic [REG_NUM-1:0] busy;
   logic [REG_NUM-1:0] busy_next;
   logic               rs1_haz;
   logic               rs2_haz;

   // Clear first so a same-cycle set of the same register wins; x0 is pinned low.
   always_comb begin
      busy_next = busy;
      if (clr_en) begin
         busy_next[clr_idx] = 1'b0;
      end
      if (set_en && (set_idx != '0)) begin
         busy_next[set_idx] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   // A bit being cleared this cycle does not hazard: the writer's result is already available.
   assign rs1_haz = rs1_rd && (rs1_idx != '0) && busy[rs1_idx] &&
                    !(clr_en && (clr_idx == rs1_idx));
   assign rs2_haz = rs2_rd && (rs2_idx != '0) && busy[rs2_idx] &&
                    !(clr_en && (clr_idx == rs2_idx));

   assign hazard = rs1_haz | rs2_haz;

endmodule

// File: rtl/stage_ctrl.sv
// Front-end stage controller: hazard/fence/window stalls and mispredict redirect-then-drain.
module stage_ctrl #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned STC_PC_WIDTH = 32,
   parameter int unsigned REG_NUM      = stc_pkg::REG_NUM,
   parameter int unsigned RIDX_WIDTH   = stc_pkg::RIDX_WIDTH,
   parameter int unsigned INFL_WIDTH   = stc_pkg::INFL_WIDTH
) (
   input  logic                    fclk_i,
   input  logic                    rst_i,
   input  logic                    dcu_vld_i,
   input  logic                    dpu_rdy_i,
   input  logic [RIDX_WIDTH-1:0]   dcu_rs1_i,
   input  logic [RIDX_WIDTH-1:0]   dcu_rs2_i,
   input  logic                    dcu_rs1_rd_i,
   input  logic                    dcu_rs2_rd_i,
   input  logic [RIDX_WIDTH-1:0]   dcu_rd_i,
   input  logic                    dcu_rd_wr_i,
   input  logic                    dcu_fence_i,
   input  logic                    exu_br_vld_i,
   input  logic                    exu_br_mispred_i,
   input  logic [STC_PC_WIDTH-1:0] exu_br_pc_i,
   input  logic                    wbu_vld_i,
   input  logic [RIDX_WIDTH-1:0]   wbu_rd_i,
   input  logic                    wbu_rd_wr_i,
   output logic                    stc_stall_o,
   output logic                    stc_redirect_o,
   output logic [STC_PC_WIDTH-1:0] stc_pc_o,
   output logic                    stc_idle_o
);

   import stc_pkg::*;

   localparam logic [INFL_WIDTH-1:0] INFL_MAX = '1;

   stc_state_e              state;
   logic [INFL_WIDTH-1:0]   count;
   logic                    redirect;
   logic [STC_PC_WIDTH-1:0] pc;

   logic issue;
   logic hazard;
   logic retire;
   logic count_zero;
   logic mispred;

   assign count_zero = (count == '0);
   assign mispred    = exu_br_vld_i & exu_br_mispred_i;

   assign stc_stall_o = (state != StRun) |
                        (dcu_vld_i & (hazard | (dcu_fence_i & ~count_zero) |
                                      (count == INFL_MAX)));

   assign issue = dcu_vld_i & dpu_rdy_i & ~stc_stall_o;

   // A retire with nothing in flight is dropped so the counter never wraps.
   assign retire = wbu_vld_i & ~count_zero;

   stc_scoreboard #(
      .REG_NUM    (REG_NUM),
      .RIDX_WIDTH (RIDX_WIDTH)
   ) u_scoreboard (
      .clk     (fclk_i),
      .rst     (rst_i),
      .set_en  (issue & dcu_rd_wr_i),
      .set_idx (dcu_rd_i),
      .clr_en  (wbu_vld_i & wbu_rd_wr_i),
      .clr_idx (wbu_rd_i),
      .rs1_idx (dcu_rs1_i),
      .rs1_rd  (dcu_rs1_rd_i),
      .rs2_idx (dcu_rs2_i),
      .rs2_rd  (dcu_rs2_rd_i),
      .hazard  (hazard)
   );

   always_ff @(posedge fclk_i) begin
      if (rst_i) begin
         count <= '0;
      end else if (issue && !retire) begin
         count <= count + 1'b1;
      end else if (!issue && retire) begin
         count <= count - 1'b1;
      end
   end

   // Resolutions seen outside RUN belong to the flushed path and are ignored.
   always_ff @(posedge fclk_i) begin
      if (rst_i) begin
         state    <= StRun;
         redirect <= 1'b0;
         pc       <= '0;
      end else begin
         redirect <= 1'b0;
         unique case (state)
            StRun: begin
               if (mispred) begin
                  state    <= StRedir;
                  redirect <= 1'b1;
                  pc       <= exu_br_pc_i;
               end
            end
            StRedir: begin
               state <= StDrain;
            end
            StDrain: begin
               if (count_zero) begin
                  state <= StRun;
               end
            end
            default: begin
               state <= StRun;
            end
         endcase
      end
   end

   assign stc_redirect_o = redirect;
   assign stc_pc_o       = pc;
   assign stc_idle_o     = count_zero & (state == StRun);

endmodule

// File: tb/tb_stage_ctrl.sv
// Directed bench for stage_ctrl: stimulus pushes per-cycle expectations, a negedge monitor checks.
module tb_stage_ctrl;

   localparam int unsigned PCW = 32;
   localparam int unsigned RW  = 5;

   logic           clk;
   logic           rst;
   logic           dcu_vld;
   logic           dpu_rdy;
   logic [RW-1:0]  dcu_rs1;
   logic [RW-1:0]  dcu_rs2;
   logic           dcu_rs1_rd;
   logic           dcu_rs2_rd;
   logic [RW-1:0]  dcu_rd;
   logic           dcu_rd_wr;
   logic           dcu_fence;
   logic           br_vld;
   logic           br_mispred;
   logic [PCW-1:0] br_pc;
   logic           wbu_vld;
   logic [RW-1:0]  wbu_rd;
   logic           wbu_rd_wr;
   logic           stall;
   logic           redirect;
   logic [PCW-1:0] pc;
   logic           idle;

   typedef struct {
      string          name;
      logic           stall;
      logic           redir;
      logic [PCW-1:0] pc;
      logic           idle;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   errors;

   stage_ctrl u_dut (
      .fclk_i           (clk),
      .rst_i            (rst),
      .dcu_vld_i        (dcu_vld),
      .dpu_rdy_i        (dpu_rdy),
      .dcu_rs1_i        (dcu_rs1),
      .dcu_rs2_i        (dcu_rs2),
      .dcu_rs1_rd_i     (dcu_rs1_rd),
      .dcu_rs2_rd_i     (dcu_rs2_rd),
      .dcu_rd_i         (dcu_rd),
      .dcu_rd_wr_i      (dcu_rd_wr),
      .dcu_fence_i      (dcu_fence),
      .exu_br_vld_i     (br_vld),
      .exu_br_mispred_i (br_mispred),
      .exu_br_pc_i      (br_pc),
      .wbu_vld_i        (wbu_vld),
      .wbu_rd_i         (wbu_rd),
      .wbu_rd_wr_i      (wbu_rd_wr),
      .stc_stall_o      (stall),
      .stc_redirect_o   (redirect),
      .stc_pc_o         (pc),
      .stc_idle_o       (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string n, input string f, input logic [PCW-1:0] got,
                      input logic [PCW-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s.%s got 0x%0h want 0x%0h", n, f, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         cmp(e.name, "stall", {31'd0, stall}, {31'd0, e.stall});
         cmp(e.name, "redirect", {31'd0, redirect}, {31'd0, e.redir});
         cmp(e.name, "pc", pc, e.pc);
         cmp(e.name, "idle", {31'd0, idle}, {31'd0, e.idle});
      end
   end

   task automatic idle_in();
      dcu_vld    = 1'b0;
      dpu_rdy    = 1'b1;
      dcu_rs1    = '0;
      dcu_rs2    = '0;
      dcu_rs1_rd = 1'b0;
      dcu_rs2_rd = 1'b0;
      dcu_rd     = '0;
      dcu_rd_wr  = 1'b0;
      dcu_fence  = 1'b0;
      br_vld     = 1'b0;
      br_mispred = 1'b0;
      br_pc      = '0;
      wbu_vld    = 1'b0;
      wbu_rd     = '0;
      wbu_rd_wr  = 1'b0;
   endtask

   task automatic dcu(input logic [RW-1:0] rs1, input logic r1, input logic [RW-1:0] rs2,
                      input logic r2, input logic [RW-1:0] rd, input logic wr,
                      input logic fence);
      dcu_vld    = 1'b1;
      dpu_rdy    = 1'b1;
      dcu_rs1    = rs1;
      dcu_rs1_rd = r1;
      dcu_rs2    = rs2;
      dcu_rs2_rd = r2;
      dcu_rd     = rd;
      dcu_rd_wr  = wr;
      dcu_fence  = fence;
   endtask

   task automatic wb(input logic [RW-1:0] rd, input logic wr);
      wbu_vld   = 1'b1;
      wbu_rd    = rd;
      wbu_rd_wr = wr;
   endtask

   task automatic br(input logic [PCW-1:0] target);
      br_vld     = 1'b1;
      br_mispred = 1'b1;
      br_pc      = target;
   endtask

   // Queue what the DUT must show during this cycle, then advance to just past the next edge.
   task automatic cyc(input string n, input logic st, input logic rd, input logic [PCW-1:0] p,
                      input logic idl);
      exp_t e;
      e.name  = n;
      e.stall = st;
      e.redir = rd;
      e.pc    = p;
      e.idle  = idl;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      idle_in();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      idle_in(); cyc("reset", 0, 0, 32'h0, 1);

      // RAW on x5 with write-through release
      idle_in(); dcu(0, 0, 0, 0, 5, 1, 0);             cyc("raw_issue", 0, 0, 32'h0, 1);
      idle_in(); dcu(5, 1, 0, 0, 0, 0, 0);             cyc("raw_stall1", 1, 0, 32'h0, 0);
      idle_in(); dcu(5, 1, 0, 0, 0, 0, 0);             cyc("raw_stall2", 1, 0, 32'h0, 0);
      idle_in(); dcu(5, 1, 0, 0, 0, 0, 0); wb(5, 1);   cyc("raw_wthru", 0, 0, 32'h0, 0);
      idle_in(); wb(0, 0);                             cyc("raw_drain", 0, 0, 32'h0, 0);
      idle_in();                                       cyc("raw_idle", 0, 0, 32'h0, 1);

      // set/clear collision on x7
      idle_in(); dcu(0, 0, 0, 0, 7, 1, 0);             cyc("col_issue", 0, 0, 32'h0, 1);
      idle_in(); dcu(0, 0, 0, 0, 7, 1, 0); wb(7, 1);   cyc("col_same", 0, 0, 32'h0, 0);
      idle_in(); dcu(0, 0, 7, 1, 0, 0, 0);             cyc("col_stall", 1, 0, 32'h0, 0);
      idle_in(); dcu(0, 0, 7, 1, 0, 0, 0); wb(7, 1);   cyc("col_wthru", 0, 0, 32'h0, 0);
      idle_in(); wb(0, 0);                             cyc("col_drain", 0, 0, 32'h0, 0);
      idle_in();                                       cyc("col_idle", 0, 0, 32'h0, 1);

      // x0 never busy
      idle_in(); dcu(0, 0, 0, 0, 0, 1, 0);             cyc("x0_wr", 0, 0, 32'h0, 1);
      idle_in(); dcu(0, 1, 0, 1, 0, 0, 0);             cyc("x0_rd", 0, 0, 32'h0, 0);
      idle_in(); wb(0, 1);                             cyc("x0_ret1", 0, 0, 32'h0, 0);
      idle_in(); wb(0, 1);                             cyc("x0_ret2", 0, 0, 32'h0, 0);
      idle_in();                                       cyc("x0_idle", 0, 0, 32'h0, 1);

      // window full at 7, then FENCE with 2 in flight
      for (int i = 0; i < 7; i++) begin
         idle_in(); dcu(0, 0, 0, 0, 0, 0, 0);          cyc("win_fill", 0, 0, 32'h0, (i == 0));
      end
      idle_in(); dcu(0, 0, 0, 0, 0, 0, 0);             cyc("win_full", 1, 0, 32'h0, 0);
      idle_in(); dcu(0, 0, 0, 0, 0, 0, 0); wb(0, 0);   cyc("win_full_ret", 1, 0, 32'h0, 0);
      idle_in(); dcu(0, 0, 0, 0, 0, 0, 0);             cyc("win_resume", 0, 0, 32'h0, 0);
      for (int i = 0; i < 5; i++) begin
         idle_in(); wb(0, 0);                          cyc("win_ret", 0, 0, 32'h0, 0);
      end
      idle_in(); dcu(0, 0, 0, 0, 0, 0, 1);             cyc("fence_stall", 1, 0, 32'h0, 0);
      idle_in(); dcu(0, 0, 0, 0, 0, 0, 1); wb(0, 0);   cyc("fence_ret1", 1, 0, 32'h0, 0);
      idle_in(); dcu(0, 0, 0, 0, 0, 0, 1); wb(0, 0);   cyc("fence_ret2", 1, 0, 32'h0, 0);
      idle_in(); dcu(0, 0, 0, 0, 0, 0, 1);             cyc("fence_go", 0, 0, 32'h0, 1);
      idle_in(); wb(0, 0);                             cyc("fence_done", 0, 0, 32'h0, 0);
      idle_in();                                       cyc("fence_idle", 0, 0, 32'h0, 1);

      // mispredict with 3 in flight, wrong-path resolution during drain
      for (int i = 0; i < 3; i++) begin
         idle_in(); dcu(0, 0, 0, 0, 0, 0, 0);          cyc("mp_fill", 0, 0, 32'h0, (i == 0));
      end
      idle_in(); br(32'h100);                          cyc("mp_br", 0, 0, 32'h0, 0);
      idle_in(); wb(0, 0);                             cyc("mp_redir", 1, 1, 32'h100, 0);
      idle_in(); wb(0, 0); br(32'h200);                cyc("mp_drain_br", 1, 0, 32'h100, 0);
      idle_in(); wb(0, 0);                             cyc("mp_drain", 1, 0, 32'h100, 0);
      idle_in(); dcu(0, 0, 0, 0, 0, 0, 0);             cyc("mp_drain_end", 1, 0, 32'h100, 0);
      idle_in();                                       cyc("mp_run", 0, 0, 32'h100, 1);

      // minimum two stall cycles with nothing in flight
      idle_in(); br(32'h300);                          cyc("min_br", 0, 0, 32'h100, 1);
      idle_in();                                       cyc("min_redir", 1, 1, 32'h300, 0);
      idle_in();                                       cyc("min_drain", 1, 0, 32'h300, 0);
      idle_in();                                       cyc("min_run", 0, 0, 32'h300, 1);

      // reset during DRAIN clears state, count, pc and scoreboard
      idle_in(); dcu(0, 0, 0, 0, 9, 1, 0);             cyc("rd_fill1", 0, 0, 32'h300, 1);
      idle_in(); dcu(0, 0, 0, 0, 9, 1, 0);             cyc("rd_fill2", 0, 0, 32'h300, 0);
      idle_in(); br(32'h400);                          cyc("rd_br", 0, 0, 32'h300, 0);
      idle_in();                                       cyc("rd_redir", 1, 1, 32'h400, 0);
      idle_in(); rst = 1'b1;                           cyc("rd_drain", 1, 0, 32'h400, 0);
      rst = 1'b0;
      idle_in(); dcu(9, 1, 0, 0, 0, 0, 0);             cyc("rd_after", 0, 0, 32'h0, 1);
      idle_in(); wb(0, 0);                             cyc("rd_ret", 0, 0, 32'h0, 0);
      idle_in();                                       cyc("rd_idle", 0, 0, 32'h0, 1);

      // reset during REDIR: no further pulse
      idle_in(); br(32'h500);                          cyc("rr_br", 0, 0, 32'h0, 1);
      idle_in(); rst = 1'b1;                           cyc("rr_redir", 1, 1, 32'h500, 0);
      rst = 1'b0;
      idle_in();                                       cyc("rr_after", 0, 0, 32'h0, 1);
      idle_in();                                       cyc("rr_quiet", 0, 0, 32'h0, 1);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
         @(posedge clk);
      end
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_queue got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
